// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory stage.
// Contents: funct3 size/sign encodings, response error codes and the
// memory-stage state encoding. Imported with import lsu_pkg::*.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_FAULT    = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational access checker for a data (or future fetch) access.
// Ports:
//   addr     in  XLEN  byte address
//   funct3   in  3     access size / signedness encoding
//   is_store in  1     1 = store, 0 = load
//   err      out 2     ERR_OK / ERR_MISALIGN / ERR_FAULT / ERR_ILLEGAL
// Priority when several apply: illegal > misaligned > access fault.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic [XLEN-1:0] addr,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  output lsu_err_e        err
);

  logic illegal;
  logic misalign;
  logic fault;

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    fault    = |addr[XLEN-1:MEM_ADDR_BITS];

    // Stores have no signed/unsigned variants, so only B/H/W are legal.
    if (is_store) begin
      illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end

    if ((funct3 == F3_H) || (funct3 == F3_HU)) begin
      misalign = addr[0];
    end else if (funct3 == F3_W) begin
      misalign = |addr[1:0];
    end

    err = ERR_OK;
    if (illegal) begin
      err = ERR_ILLEGAL;
    end else if (misalign) begin
      err = ERR_MISALIGN;
    end else if (fault) begin
      err = ERR_FAULT;
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: accepts one request from execute, checks it,
// drives the data memory for exactly one cycle and returns a registered
// response to write-back. Faulting requests never reach memory.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr/wdata/funct3/is_store/rd   request fields
//   mem_address/write_data/funct3/read_enable/write_enable  to data memory
//   mem_read_data              combinational read data from data memory
//   resp_valid/resp_ready      response handshake
//   resp_data/rd/is_store/err  response fields
// Build option LSU_PERF_CNT_EN adds perf_loads, perf_stores, perf_errs
// (32-bit wrapping event counters).
//
// state | meaning
// IDLE  | ready for a request; checks and latches it on acceptance
// ISSUE | single cycle driving the data memory; load data captured at end
// RESP  | response presented, held stable until resp_ready
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 12,
  parameter int XLEN          = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  input  logic            req_is_store,
  input  logic [4:0]      req_rd,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic [2:0]      mem_funct3,
  output logic            mem_read_enable,
  output logic            mem_write_enable,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_is_store,
  output logic [1:0]      resp_err
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_errs
`endif
);

  lsu_state_e      state;
  lsu_state_e      state_nxt;
  lsu_err_e        chk_err;
  logic            live_q;
  logic            accept;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            store_q;

  lsu_access_check #(
    .XLEN          (XLEN),
    .MEM_ADDR_BITS (MEM_ADDR_BITS)
  ) u_check (
    .addr     (req_addr),
    .funct3   (req_funct3),
    .is_store (req_is_store),
    .err      (chk_err)
  );

  // live_q holds ready low for the first cycle after reset as well as
  // during reset itself.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = live_q && !reset;
        if (req_valid && req_ready) begin
          state_nxt = (chk_err == ERR_OK) ? ISSUE : RESP;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Memory sees nothing but zeros outside the ISSUE cycle.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_funct3       = 3'd0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    if (state == ISSUE) begin
      mem_address      = addr_q;
      mem_write_data   = wdata_q;
      mem_funct3       = funct3_q;
      mem_read_enable  = !store_q;
      mem_write_enable = store_q;
    end
  end

  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      live_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      funct3_q      <= 3'd0;
      store_q       <= 1'b0;
      resp_data     <= '0;
      resp_rd       <= 5'd0;
      resp_is_store <= 1'b0;
      resp_err      <= ERR_OK;
    end else begin
      state  <= state_nxt;
      live_q <= 1'b1;
      if (accept) begin
        addr_q        <= req_addr;
        wdata_q       <= req_wdata;
        funct3_q      <= req_funct3;
        store_q       <= req_is_store;
        resp_rd       <= req_rd;
        resp_is_store <= req_is_store;
        resp_err      <= chk_err;
        resp_data     <= '0;
      end
      if (state == ISSUE) begin
        resp_data <= store_q ? '0 : mem_read_data;
      end
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errs   <= 32'd0;
    end else begin
      if ((state == ISSUE) && !store_q) perf_loads <= perf_loads + 32'd1;
      if ((state == ISSUE) && store_q) perf_stores <= perf_stores + 32'd1;
      if (accept && (chk_err != ERR_OK)) perf_errs <= perf_errs + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Accepts one memory request from the execute stage over a valid/ready handshake, checks it, and drives the data memory's address, write_data, funct3 and enable inputs for exactly one cycle.
- Registers the load result and returns it with a ready/valid response to write-back.
- Faulting requests never reach memory.

Parameters:
- MEM_ADDR_BITS, 12: byte-address bits decoded by data memory; higher nonzero address bits are an access fault.
- XLEN, 32: data/address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (low bytes used for SB/SH)
- req_funct3  in  3  instruction[14:12]
- req_is_store  in  1  1=store, 0=load
- req_rd  in  5  destination register, passed through
- mem_address  out  XLEN  to data memory
- mem_write_data  out  XLEN  to data memory
- mem_funct3  out  3  to data memory
- mem_read_enable  out  1  to data memory
- mem_write_enable  out  1  to data memory
- mem_read_data  in  XLEN  combinational read data from memory
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  XLEN  load result; 0 for stores and errors
- resp_rd  out  5  echoed req_rd
- resp_is_store  out  1  echoed req_is_store
- resp_err  out  2  0=OK, 1=misaligned, 2=access fault, 3=illegal funct3

Behaviour:
- Reset is synchronous, active-high. clk and reset are the only clock/reset. On reset: state=IDLE, req_ready=0 in the reset cycle then 1, resp_valid=0, resp_data=0, resp_rd=0, resp_is_store=0, resp_err=0, mem_* outputs 0.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: req_ready=1. On req_valid, latch addr/wdata/funct3/is_store/rd and compute err. If err==0 go to ISSUE, else go to RESP with resp_err=err and resp_data=0.
  - ISSUE (exactly one cycle): mem_address, mem_write_data and mem_funct3 come from the latched registers. mem_write_enable=is_store; mem_read_enable=!is_store. For loads, capture mem_read_data into resp_data at the end of the cycle; for stores, resp_data=0. Next state RESP.
  - RESP: resp_valid=1 and all resp_* fields held stable until resp_ready. On resp_ready go to IDLE. req_ready=0 in ISSUE and RESP.
- Latency:
  - Accept at cycle N, mem access at N+1, resp_valid at N+2.
  - Error requests: resp_valid at N+1.
  - Maximum throughput is one request per 3 cycles.
- mem_* outputs are 0 outside ISSUE, so memory enables are never asserted in IDLE or RESP.
- Error checks, priority illegal > misaligned > fault:
  - Illegal funct3: store with funct3 outside {0,1,2}; load with funct3 in {3,6,7}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Access fault: addr[XLEN-1:MEM_ADDR_BITS] != 0.
- Byte accesses are never misaligned.
- resp_ready asserted while not in RESP has no effect.
- Reset mid-operation (ISSUE or RESP): the pending request is dropped with no response. A store in ISSUE during the reset cycle still presents write_enable; the data memory resets in the same cycle, so the result is don't-care.
- req_* inputs are ignored when req_ready=0.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- When defined: adds outputs perf_loads[31:0], perf_stores[31:0] and perf_errs[31:0].
  - perf_loads and perf_stores increment on the ISSUE cycle of a load or store.
  - perf_errs increments on acceptance of an erroring request.
  - All counters wrap at 2^32 and clear on reset.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5
  - err codes ERR_OK/ERR_MISALIGN/ERR_FAULT/ERR_ILLEGAL
  - the state enum IDLE/ISSUE/RESP
- One combinational sub-module, lsu_access_check (addr, funct3, is_store -> err), reusable by a future fetch path. The FSM and registers stay in lsu_mem_stage.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10: exactly one mem_write_enable cycle; load resp_data=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- SB addr=0x13 wdata=0xA5 on a zeroed word, then LB 0x13 and LBU 0x13: resp_data=0xFFFFFFA5 and 0x000000A5.
- LH addr=0x21 and LW addr=0x22: resp_err=1, resp_valid 1 cycle after accept, no mem enable ever asserted.
- LW addr=0x1000: resp_err=2. Store funct3=3: resp_err=3. Load funct3=3 at misaligned addr 0x1: resp_err=3 (priority).
- Hold resp_ready=0 for 5 cycles: resp fields stable, req_ready=0, req_valid pulses ignored; resp_ready=1 then returns to IDLE.
- Assert reset in ISSUE of a LW: next cycle resp_valid=0, req_ready=0, mem_* outputs 0; with LSU_PERF_CNT_EN, counters read 0.
